// File: rtl/io_responder.sv
// Memory-mapped IO responder: LED register, synchronized/debounced switches,
// sticky switch-change flag and a free-running cycle timer.
module io_responder #(
    parameter int          DB_CYCLES = 250000,
    parameter int          DB_W      = 18,
    parameter logic [31:0] IO_BASE   = 32'hFFFFFC00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic        sw_changed
);

    // Word indices (offset[9:2]) of the mapped registers
    localparam logic [7:0] W_LED   = 8'h18;
    localparam logic [7:0] W_SW    = 8'h1C;
    localparam logic [7:0] W_STAT  = 8'h1D;
    localparam logic [7:0] W_TIMER = 8'h1E;

    logic [15:0]   led_q,   led_d;
    logic [15:0]   s1_q,    s2_q;
    logic [15:0]   sw_db_q, sw_db_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic          chg_q,   chg_d;
    logic [31:0]   timer_q, timer_d;

    logic          hit;
    logic [7:0]    word;
    logic          rd_hit, wr_hit;
    logic          db_accept;
    logic          unused_bits;

    assign hit         = (addr[31:10] == IO_BASE[31:10]);
    assign word        = addr[9:2];
    assign rd_hit      = io_read & hit;
    assign wr_hit      = io_write & hit;
    assign unused_bits = ^{addr[1:0], write_data[31:16]};

    // Reads see registered state only, so a combined read/write returns the pre-write value
    always_comb begin
        read_data = 32'h0;
        if (rd_hit) begin
            case (word)
                W_LED:   read_data = {16'h0, led_q};
                W_SW:    read_data = {16'h0, sw_db_q};
                W_STAT:  read_data = {31'h0, chg_q};
                W_TIMER: read_data = timer_q;
                default: read_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        led_d     = led_q;
        sw_db_d   = sw_db_q;
        cnt_d     = cnt_q;
        chg_d     = chg_q;
        timer_d   = timer_q + 32'd1;
        db_accept = 1'b0;

        if (wr_hit && word == W_LED) begin
            led_d = write_data[15:0];
        end
        if (wr_hit && word == W_TIMER) begin
            timer_d = 32'h0;
        end

        // Count only resets when s2 returns to the accepted value, not on a new value mid-count
        if (s2_q == sw_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            sw_db_d   = s2_q;
            cnt_d     = '0;
            db_accept = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (db_accept) begin
            chg_d = 1'b1;
        end else if (rd_hit && word == W_STAT) begin
            chg_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q   <= 16'h0;
            s1_q    <= 16'h0;
            s2_q    <= 16'h0;
            sw_db_q <= 16'h0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            timer_q <= 32'h0;
        end else begin
            led_q   <= led_d;
            s1_q    <= switch;
            s2_q    <= s1_q;
            sw_db_q <= sw_db_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            timer_q <= timer_d;
        end
    end

    assign led        = led_q;
    assign sw_changed = chg_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder with a short debounce window (DB_CYCLES=4).
module tb_io_responder;

    localparam logic [31:0] A_LED   = 32'hFFFFFC60;
    localparam logic [31:0] A_SW    = 32'hFFFFFC70;
    localparam logic [31:0] A_STAT  = 32'hFFFFFC74;
    localparam logic [31:0] A_TIMER = 32'hFFFFFC78;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic [15:0] switch = 16'h0;
    logic [15:0] led;
    logic        sw_changed;

    typedef struct {
        logic [31:0] rd;
        logic [15:0] led;
        logic        chg;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] led_m = 16'h0;

    io_responder #(
        .DB_CYCLES(4),
        .DB_W     (3),
        .IO_BASE  (32'hFFFFFC00)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_read   (io_read),
        .io_write  (io_write),
        .addr      (addr),
        .write_data(write_data),
        .read_data (read_data),
        .switch    (switch),
        .led       (led),
        .sw_changed(sw_changed)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every read access is matched against the next queued expectation
    always @(negedge clock) begin
        if (io_read) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_read: got %h expected no access", read_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".rdata"}, read_data, e.rd);
                check({e.name, ".led"}, {16'h0, led}, {16'h0, e.led});
                check({e.name, ".chg"}, {31'h0, sw_changed}, {31'h0, e.chg});
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge; each access takes one cycle
    task automatic rd(input logic [31:0] a, input logic [31:0] e_rd, input logic e_chg, input string nm);
        io_read = 1'b1;
        addr    = a;
        exp_q.push_back('{e_rd, led_m, e_chg, nm});
        @(posedge clock); #1;
        io_read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_write   = 1'b1;
        addr       = a;
        write_data = d;
        @(posedge clock); #1;
        io_write = 1'b0;
    endtask

    task automatic rdwr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e_rd,
                        input logic e_chg, input string nm);
        io_write   = 1'b1;
        write_data = d;
        rd(a, e_rd, e_chg, nm);
        io_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clock); #1;
        rd(A_LED,  32'h0, 1'b0, "reset_led");
        rd(A_SW,   32'h0, 1'b0, "reset_sw");
        rd(A_STAT, 32'h0, 1'b0, "reset_stat");
        reset = 1'b0;
        idle(1);

        // LED write, read-back, and combined read/write shows the old value
        wr(A_LED, 32'h0000A5C3); led_m = 16'hA5C3;
        rd(A_LED, 32'h0000A5C3, 1'b0, "led_rb");
        rdwr(A_LED, 32'hFFFF1234, 32'h0000A5C3, 1'b0, "led_rdwr");
        led_m = 16'h1234;
        rd(A_LED, 32'h00001234, 1'b0, "led_rb2");
        rd(32'hFFFFFC63, 32'h00001234, 1'b0, "led_lowbits");

        // Switch edge reaches sw_db on the sixth edge after the change
        switch = 16'h00F0;
        for (int k = 0; k < 7; k++)
            rd(A_SW, (k < 6) ? 32'h0 : 32'h000000F0, (k < 6) ? 1'b0 : 1'b1, $sformatf("sw_lat%0d", k));
        rd(A_STAT, 32'h1, 1'b1, "stat_set");
        rd(A_STAT, 32'h0, 1'b0, "stat_clr");

        switch = 16'h0000;
        idle(8);
        rd(A_SW,   32'h0, 1'b1, "sw_back0");
        rd(A_STAT, 32'h1, 1'b1, "stat_back0");

        // Three-cycle glitch must be rejected
        switch = 16'h0001;
        idle(3);
        switch = 16'h0000;
        idle(8);
        rd(A_SW,   32'h0, 1'b0, "glitch_sw");
        rd(A_STAT, 32'h0, 1'b0, "glitch_stat");

        // STAT read on the accepting edge: old flag read, set wins
        switch = 16'h00F0;
        idle(5);
        rd(A_STAT, 32'h0, 1'b0, "stat_race");
        rd(A_STAT, 32'h1, 1'b1, "stat_after_race");
        rd(A_STAT, 32'h0, 1'b0, "stat_after_clr");
        rd(A_SW, 32'h000000F0, 1'b0, "sw_f0");

        // Timer cleared by a write then counts
        wr(A_TIMER, 32'hDEADBEEF);
        idle(10);
        rd(A_TIMER, 32'h0000000A, 1'b0, "timer_10");

        // Unmapped offsets and misses
        wr(32'hFFFFFC80, 32'h0000FFFF);
        rd(32'hFFFFFC80, 32'h0, 1'b0, "unmapped_rd");
        wr(32'h00000060, 32'h00001111);
        rd(32'h00000060, 32'h0, 1'b0, "miss_rd");
        rd(32'hFFFFFC64, 32'h0, 1'b0, "gap_rd");
        rd(A_LED, 32'h00001234, 1'b0, "led_kept");

        // Asynchronous reset in the middle of a debounce
        switch = 16'h000F;
        idle(3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_led", {16'h0, led}, 32'h0);
        check("async_rst_chg", {31'h0, sw_changed}, 32'h0);
        led_m = 16'h0;
        @(posedge clock); #1;
        rd(A_SW, 32'h0, 1'b0, "rst_sw");
        reset = 1'b0;
        idle(5);
        rd(A_SW, 32'h0, 1'b0, "redb_before");
        rd(A_SW, 32'h0000000F, 1'b1, "redb_after");

        idle(2);
        if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
